// File: rtl/seg_scan_decoder_if.sv
// Display-bus monitor interface: scanned segment bus in, decoded frame out.
// The bench holds the master side and the decoder holds the slave side.
interface seg_scan_decoder_if;
  logic [7:0]  seg;
  logic [1:0]  seg_select;
  logic [11:0] bcd;
  logic [9:0]  value;
  logic        value_valid;
  logic        in_range;
  logic        code_err;
  logic        timeout;

  modport master (
    output seg, seg_select,
    input  bcd, value, value_valid,
    input  in_range, code_err, timeout
  );

  modport slave (
    input  seg, seg_select,
    output bcd, value, value_valid,
    output in_range, code_err, timeout
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of the muxed 7-seg bus: debounce each scanned digit,
// decode it to BCD, rebuild the 3-digit frame and convert it to binary.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_decoder_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t        state;
  logic [8:0]    smp;
  logic [8:0]    prv;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic [2:0]    have;
  logic [3:0]    dig_h;
  logic [3:0]    dig_t;
  logic [3:0]    dig_o;
  logic [11:0]   bcd_q;
  logic [9:0]    value_q;
  logic          valid_q;
  logic          range_q;
  logic          err_q;
  logic          tout_q;

  function automatic logic [4:0] decode(input logic [6:0] p);
    unique case (p)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      default: decode = 5'h00;
    endcase
  endfunction

  function automatic logic [9:0] to_bin(
    input logic [3:0] h,
    input logic [3:0] t,
    input logic [3:0] o
  );
    to_bin = {h, 6'b0} + {1'b0, h, 5'b0}
           + {4'b0, h, 2'b0} + {3'b0, t, 3'b0}
           + {5'b0, t, 1'b0} + {6'b0, o};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= '0;
      prv <= '0;
      cnt <= '0;
    end else begin
      smp <= {bus.seg_select, bus.seg[6:0]};
      prv <= smp;
      if (smp != prv)
        cnt <= CW'(1);
      else if (cnt != CW'(STABLE_CYC))
        cnt <= cnt + 1'b1;
    end
  end

  // Fires on the edge where the counter steps up to STABLE_CYC
  logic       cap;
  logic [4:0] dec;
  logic       legal;
  logic [2:0] bit_sel;
  logic [3:0] nh;
  logic [3:0] nt;
  logic [3:0] no;
  logic [2:0] nhave;
  logic [9:0] nval;

  assign dec   = decode(smp[6:0]);
  assign legal = dec[4];
  assign cap   = (smp == prv)
              && (cnt == CW'(STABLE_CYC - 1))
              && (smp[8:7] != 2'd3);

  always_comb begin
    nh      = dig_h;
    nt      = dig_t;
    no      = dig_o;
    bit_sel = 3'b000;
    unique case (smp[8:7])
      2'd0: begin
        nh      = dec[3:0];
        bit_sel = 3'b001;
      end
      2'd1: begin
        nt      = dec[3:0];
        bit_sel = 3'b010;
      end
      2'd2: begin
        no      = dec[3:0];
        bit_sel = 3'b100;
      end
      default: ;
    endcase
  end

  assign nhave = have | bit_sel;
  assign nval  = to_bin(nh, nt, no);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      have    <= '0;
      timer   <= '0;
      dig_h   <= '0;
      dig_t   <= '0;
      dig_o   <= '0;
      bcd_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      range_q <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
      unique case (state)
        IDLE, EMIT: begin
          have  <= 3'b000;
          state <= IDLE;
          if (cap && legal) begin
            dig_h <= nh;
            dig_t <= nt;
            dig_o <= no;
            have  <= bit_sel;
            timer <= '0;
            state <= COLLECT;
          end else if (cap) begin
            err_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (cap && legal) begin
            dig_h <= nh;
            dig_t <= nt;
            dig_o <= no;
            have  <= nhave;
            timer <= '0;
            // Result registers load here so the pulse lands in EMIT
            if (nhave == 3'b111) begin
              bcd_q   <= {nh, nt, no};
              value_q <= nval;
              range_q <= (nval <= 10'd255);
              valid_q <= 1'b1;
              state   <= EMIT;
            end
          end else if (cap) begin
            err_q <= 1'b1;
            have  <= 3'b000;
            state <= IDLE;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            tout_q <= 1'b1;
            have   <= 3'b000;
            state  <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd         = bcd_q;
  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.in_range    = range_q;
  assign bus.code_err    = err_q;
  assign bus.timeout     = tout_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random frames,
// checked against a digit-level frame model.
module tb_seg_scan_decoder;
  localparam int STABLE = 4;
  localparam int TMO    = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(
    .STABLE_CYC (STABLE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int n_valid = 0;
  int n_err   = 0;
  int n_to    = 0;

  always @(posedge clk) begin
    #1;
    if (bus.value_valid === 1'b1) n_valid++;
    if (bus.code_err === 1'b1)    n_err++;
    if (bus.timeout === 1'b1)     n_to++;
  end

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int m_dig [3];
  bit m_have [3];
  int m_age;
  int e_valid = 0;
  int e_err   = 0;
  int e_to    = 0;
  int e_val   = 0;
  int e_bcd   = 0;
  int e_rng   = 0;

  function automatic int lookup(input logic [6:0] p);
    lookup = -1;
    for (int i = 0; i < 10; i++)
      if (pats[i] == p) lookup = i;
  endfunction

  function automatic bit collecting();
    collecting = m_have[0] | m_have[1] | m_have[2];
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < 3; i++) m_have[i] = 1'b0;
    m_age = 0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_nvalid"}, n_valid, e_valid);
    chk({tag, "_nerr"}, n_err, e_err);
    chk({tag, "_nto"}, n_to, e_to);
    chk({tag, "_bcd"}, 32'(bus.bcd), e_bcd);
    chk({tag, "_value"}, 32'(bus.value), e_val);
    chk({tag, "_inrange"}, 32'(bus.in_range), e_rng);
  endtask

  // Show one pattern on one digit for n cycles, then update the model
  task automatic step(input int sel, input logic [6:0] p,
                      input int n, input string tag);
    int d;
    bus.seg_select = sel[1:0];
    bus.seg        = {1'($urandom), p};
    repeat (n) @(negedge clk);
    if (n >= STABLE && sel != 3) begin
      d = lookup(p);
      if (d < 0) begin
        e_err++;
        clear_frame();
      end else begin
        m_dig[sel]  = d;
        m_have[sel] = 1'b1;
        m_age       = n - STABLE;
        if (m_have[0] && m_have[1] && m_have[2]) begin
          e_valid++;
          e_val = m_dig[0] * 100 + m_dig[1] * 10 + m_dig[2];
          e_bcd = m_dig[0] * 256 + m_dig[1] * 16 + m_dig[2];
          e_rng = (e_val <= 255) ? 1 : 0;
          clear_frame();
        end
      end
    end else if (collecting()) begin
      m_age += n;
      if (m_age > TMO) begin
        e_to++;
        clear_frame();
      end
    end
    check_all(tag);
  endtask

  task automatic frame(input int h, input int t,
                       input int o, input string tag);
    step(0, pats[h], 8, tag);
    step(1, pats[t], 8, tag);
    step(2, pats[o], 8, tag);
  endtask

  initial begin
    logic [6:0] p;
    int d;
    int n;
    clear_frame();
    rst            = 1'b1;
    bus.seg_select = 2'd3;
    bus.seg        = 8'h00;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset_valid", 32'(bus.value_valid), 0);
    rst = 1'b0;
    step(3, 7'h00, 6, "idle");

    frame(1, 2, 3, "t1");
    chk("t1_bcd_const", 32'(bus.bcd), 32'h123);
    chk("t1_value_const", 32'(bus.value), 123);

    frame(2, 5, 6, "t2a");
    chk("t2_value_256", 32'(bus.value), 256);
    chk("t2_inrange_0", 32'(bus.in_range), 0);
    frame(0, 0, 0, "t2b");

    step(0, pats[1], 8, "t3");
    step(1, 7'h49, 8, "t3_bad");
    frame(0, 4, 2, "t3_ok");
    chk("t3_value_42", 32'(bus.value), 42);

    step(0, pats[1], 3, "t4_short");
    step(1, pats[2], 3, "t4_short");
    step(2, pats[3], 3, "t4_short");
    for (int i = 0; i < 6; i++) begin
      step(1, pats[6], 1, "t4_glitch");
      step(1, pats[7], 1, "t4_glitch");
    end
    step(3, 7'h00, 6, "t4_idle");

    step(0, pats[9], 8, "t5");
    step(1, pats[8], 8, "t5");
    step(3, 7'h00, TMO + 76, "t5_timeout");

    step(0, pats[7], 8, "t6");
    step(1, pats[5], 8, "t6");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_frame();
    e_val = 0;
    e_bcd = 0;
    e_rng = 0;
    check_all("t6_reset");
    frame(1, 0, 0, "t6_frame");
    chk("t6_value_100", 32'(bus.value), 100);

    for (int f = 0; f < 25; f++) begin
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(0, 9) == 0) begin
          do p = 7'($urandom); while (lookup(p) >= 0);
        end else begin
          d = $urandom_range(0, 9);
          p = pats[d];
        end
        if ($urandom_range(0, 4) == 0) n = $urandom_range(1, 3);
        else n = $urandom_range(7, 10);
        step(s, p, n, "rand");
      end
      if ($urandom_range(0, 2) == 0)
        step(3, 7'($urandom), $urandom_range(1, 10), "rand_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
